adt7410_measure_fsm: RTL

Measurement sequencer for the ADT7410 temperature sensor application, sitting between the sensor FSM and the I2C master core. On a one-cycle start request it configures the sensor for a one-shot conversion, waits a programmable conversion time, reads the 16-bit temperature register and returns both bytes with a one-cycle done pulse. Any I2C error reported during a transfer aborts the sequence with a one-cycle error pulse.

---
 rtl/adt7410_measure_fsm_pkg.sv | 34 +++
 rtl/adt7410_measure_fsm_if.sv | 24 ++
 rtl/adt7410_measure_fsm_wait_timer.sv | 27 ++
 rtl/adt7410_measure_fsm.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/adt7410_measure_fsm_pkg.sv
// Shared definitions for the ADT7410 measurement sequencer: state encoding,
// sensor register constants and the I2C address-byte helper.
package adt7410_measure_fsm_pkg;

  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_CFG_ADDR  = 4'd1;
  localparam logic [3:0] ST_CFG_REG   = 4'd2;
  localparam logic [3:0] ST_CFG_VAL   = 4'd3;
  localparam logic [3:0] ST_CFG_WAIT  = 4'd4;
  localparam logic [3:0] ST_CONV_WAIT = 4'd5;
  localparam logic [3:0] ST_PTR_ADDR  = 4'd6;
  localparam logic [3:0] ST_PTR_REG   = 4'd7;
  localparam logic [3:0] ST_PTR_WAIT  = 4'd8;
  localparam logic [3:0] ST_RD_ADDR   = 4'd9;
  localparam logic [3:0] ST_RD_WAIT   = 4'd10;
  localparam logic [3:0] ST_RD_MSB    = 4'd11;
  localparam logic [3:0] ST_RD_LSB    = 4'd12;
  localparam logic [3:0] ST_DONE      = 4'd13;
  localparam logic [3:0] ST_ERROR     = 4'd14;

  localparam logic [7:0] ADT7410_REG_TEMP    = 8'h00;
  localparam logic [7:0] ADT7410_REG_CONFIG  = 8'h03;
  localparam logic [7:0] ADT7410_CFG_ONESHOT = 8'h20;
  localparam logic [7:0] READ_COUNT          = 8'd2;

  function automatic logic [7:0] addr_byte(input logic [6:0] addr, input logic rd);
    return {addr, rd};
  endfunction

  function automatic logic is_xfer_wait(input logic [3:0] st);
    return (st == ST_CFG_WAIT) || (st == ST_PTR_WAIT) || (st == ST_RD_WAIT);
  endfunction

endpackage

// File: rtl/adt7410_measure_fsm_if.sv
// Handshake between the measurement sequencer (master) and the I2C master core (slave).
interface adt7410_measure_fsm_if #(
  parameter int DataWidth = 8
);
  logic                 receive_send_n;
  logic [7:0]           read_count;
  logic                 start_process;
  logic                 busy;
  logic                 fifo_write;
  logic [DataWidth-1:0] tx_data;
  logic                 fifo_read_next;
  logic [DataWidth-1:0] rx_data;
  logic                 error;

  modport master (
    output receive_send_n, read_count, start_process, fifo_write, tx_data, fifo_read_next,
    input  busy, rx_data, error
  );

  modport slave (
    input  receive_send_n, read_count, start_process, fifo_write, tx_data, fifo_read_next,
    output busy, rx_data, error
  );
endinterface

// File: rtl/adt7410_measure_fsm_wait_timer.sv
// 16-bit loadable down-counter with a zero flag; saturates at zero.
module adt7410_measure_fsm_wait_timer (
  input  logic        Clk_i,
  input  logic        Reset_i,
  input  logic        load_i,
  input  logic [15:0] preset_i,
  input  logic        dec_i,
  output logic        zero_o
);
  logic [15:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = preset_i;
    end else if (dec_i && (count_q != 16'd0)) begin
      count_d = count_q - 16'd1;
    end
  end

  always_ff @(posedge Clk_i) begin
    if (Reset_i) count_q <= '0;
    else         count_q <= count_d;
  end

  assign zero_o = (count_q == 16'd0);
endmodule

// File: rtl/adt7410_measure_fsm.sv
// ADT7410 measurement sequencer: one-shot config, conversion wait, 16-bit read.
//  state     | meaning
//  IDLE      | wait for Start_i
//  CFG_*     | write config register (addr, reg 0x03, one-shot 0x20), wait transfer
//  CONV_WAIT | conversion timer running
//  PTR_*     | set register pointer to temperature, wait transfer
//  RD_*      | read two bytes, pop MSB then LSB
//  DONE      | Done_o pulse
//  ERROR     | Error_o pulse
module adt7410_measure_fsm
  import adt7410_measure_fsm_pkg::*;
#(
  parameter int DataWidth = 8
) (
  input  logic                  Clk_i,
  input  logic                  Reset_i,
  input  logic                  Start_i,
  output logic                  Done_o,
  output logic                  Error_o,
  output logic [DataWidth-1:0]  Byte0_o,
  output logic [DataWidth-1:0]  Byte1_o,
  input  logic [6:0]            ParamI2CAddr_i,
  input  logic [15:0]           ParamWaitCounterPreset_i,
  adt7410_measure_fsm_if.master I2C
);
  logic [3:0]           state_d, state_q;
  logic                 entered_d, entered_q;
  logic [DataWidth-1:0] byte0_d, byte0_q, byte1_d, byte1_q;
  logic                 timer_load, timer_dec, timer_zero;
  logic                 xfer_done;

  adt7410_measure_fsm_wait_timer u_wait_timer (
    .Clk_i    (Clk_i),
    .Reset_i  (Reset_i),
    .load_i   (timer_load),
    .preset_i (ParamWaitCounterPreset_i),
    .dec_i    (timer_dec),
    .zero_o   (timer_zero)
  );

  // The core raises busy only one cycle after StartProcess, so the first wait cycle must not trust it.
  assign xfer_done = !entered_q && !I2C.busy;
  assign entered_d = (state_d != state_q);

  always_comb begin
    state_d    = state_q;
    byte0_d    = byte0_q;
    byte1_d    = byte1_q;
    timer_load = 1'b0;
    timer_dec  = 1'b0;
    if (is_xfer_wait(state_q) && I2C.error) begin
      state_d = ST_ERROR;
    end else begin
      case (state_q)
        ST_IDLE:      if (Start_i) state_d = ST_CFG_ADDR;
        ST_CFG_ADDR:  state_d = ST_CFG_REG;
        ST_CFG_REG:   state_d = ST_CFG_VAL;
        ST_CFG_VAL:   state_d = ST_CFG_WAIT;
        ST_CFG_WAIT: begin
          if (xfer_done) begin
            state_d    = ST_CONV_WAIT;
            timer_load = 1'b1;
          end
        end
        ST_CONV_WAIT: begin
          timer_dec = 1'b1;
          if (timer_zero) state_d = ST_PTR_ADDR;
        end
        ST_PTR_ADDR:  state_d = ST_PTR_REG;
        ST_PTR_REG:   state_d = ST_PTR_WAIT;
        ST_PTR_WAIT:  if (xfer_done) state_d = ST_RD_ADDR;
        ST_RD_ADDR:   state_d = ST_RD_WAIT;
        ST_RD_WAIT:   if (xfer_done) state_d = ST_RD_MSB;
        ST_RD_MSB: begin
          byte1_d = I2C.rx_data;
          state_d = ST_RD_LSB;
        end
        ST_RD_LSB: begin
          byte0_d = I2C.rx_data;
          state_d = ST_DONE;
        end
        ST_DONE:      state_d = ST_IDLE;
        ST_ERROR:     state_d = ST_IDLE;
        default:      state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk_i) begin
    if (Reset_i) begin
      state_q   <= ST_IDLE;
      entered_q <= 1'b0;
      byte0_q   <= '0;
      byte1_q   <= '0;
    end else begin
      state_q   <= state_d;
      entered_q <= entered_d;
      byte0_q   <= byte0_d;
      byte1_q   <= byte1_d;
    end
  end

  always_comb begin
    I2C.receive_send_n = 1'b0;
    I2C.read_count     = 8'd0;
    I2C.start_process  = 1'b0;
    I2C.fifo_write     = 1'b0;
    I2C.tx_data        = '0;
    I2C.fifo_read_next = 1'b0;
    Done_o             = 1'b0;
    Error_o            = 1'b0;
    case (state_q)
      ST_CFG_ADDR, ST_PTR_ADDR: begin
        I2C.fifo_write = 1'b1;
        I2C.tx_data    = DataWidth'(addr_byte(ParamI2CAddr_i, 1'b0));
      end
      ST_CFG_REG: begin
        I2C.fifo_write = 1'b1;
        I2C.tx_data    = DataWidth'(ADT7410_REG_CONFIG);
      end
      ST_CFG_VAL: begin
        I2C.fifo_write    = 1'b1;
        I2C.start_process = 1'b1;
        I2C.tx_data       = DataWidth'(ADT7410_CFG_ONESHOT);
      end
      ST_PTR_REG: begin
        I2C.fifo_write    = 1'b1;
        I2C.start_process = 1'b1;
        I2C.tx_data       = DataWidth'(ADT7410_REG_TEMP);
      end
      ST_RD_ADDR: begin
        I2C.fifo_write     = 1'b1;
        I2C.start_process  = 1'b1;
        I2C.receive_send_n = 1'b1;
        I2C.read_count     = READ_COUNT;
        I2C.tx_data        = DataWidth'(addr_byte(ParamI2CAddr_i, 1'b1));
      end
      ST_RD_MSB, ST_RD_LSB: I2C.fifo_read_next = 1'b1;
      ST_DONE:              Done_o  = 1'b1;
      ST_ERROR:             Error_o = 1'b1;
      default: ;
    endcase
  end

  assign Byte0_o = byte0_q;
  assign Byte1_o = byte1_q;
endmodule
